// File: rtl/tcdm_resp_reorder_buffer.sv
// Per-core TCDM shim: tags requests with a slot ID, tracks up to NumOutstanding
// in-flight requests and returns responses either in request order or as they arrive.
module tcdm_resp_reorder_buffer #(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter bit          InOrder        = 1'b1,
  parameter int unsigned MetaIdWidth    = $clog2(NumOutstanding)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  // core request
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [AddrWidth-1:0]                  req_addr_i,
  input  logic                                  req_wen_i,
  input  logic [DataWidth/8-1:0]                req_be_i,
  input  logic [DataWidth-1:0]                  req_data_i,
  input  logic [3:0]                            req_amo_i,
  // interconnect request
  output logic                                  out_req_valid_o,
  input  logic                                  out_req_ready_i,
  output logic [AddrWidth-1:0]                  out_req_addr_o,
  output logic                                  out_req_wen_o,
  output logic [DataWidth/8-1:0]                out_req_be_o,
  output logic [DataWidth-1:0]                  out_req_data_o,
  output logic [3:0]                            out_req_amo_o,
  output logic [MetaIdWidth-1:0]                out_req_meta_id_o,
  // interconnect response
  input  logic                                  in_resp_valid_i,
  output logic                                  in_resp_ready_o,
  input  logic [MetaIdWidth-1:0]                in_resp_meta_id_i,
  input  logic [DataWidth-1:0]                  in_resp_data_i,
  // core response
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [DataWidth-1:0]                  resp_data_o,
  output logic [MetaIdWidth-1:0]                resp_meta_id_o,
  // status
  output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o,
  output logic                                  error_o
);

  localparam int unsigned CountWidth = $clog2(NumOutstanding + 1);
  localparam logic [MetaIdWidth-1:0] PtrOne = MetaIdWidth'(1);
  localparam logic [CountWidth-1:0]  CntOne = CountWidth'(1);
  localparam logic [CountWidth-1:0]  CntMax = CountWidth'(NumOutstanding);

  logic [MetaIdWidth-1:0]    tail_q, tail_d;
  logic [CountWidth-1:0]     count_q, count_d;
  logic [NumOutstanding-1:0] alloc_q, alloc_d;
  logic                      error_q, error_d;

  logic                   full;
  logic                   stall;
  logic                   push;
  logic                   rel_valid;   // a slot is freed this cycle
  logic [MetaIdWidth-1:0] rel_idx;
  logic                   proto_err;

  // ---------------------------------------------------------------------------
  // Request path: combinational pass-through, tagged with the tail slot
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CntMax);
  // The tail slot can still be busy when responses free slots out of order.
  assign stall = full | alloc_q[tail_q];

  assign out_req_valid_o   = req_valid_i & ~stall;
  assign req_ready_o       = out_req_ready_i & ~stall;
  assign out_req_addr_o    = req_addr_i;
  assign out_req_wen_o     = req_wen_i;
  assign out_req_be_o      = req_be_i;
  assign out_req_data_o    = req_data_i;
  assign out_req_amo_o     = req_amo_i;
  assign out_req_meta_id_o = tail_q;

  assign push = req_valid_i & req_ready_o;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  if (InOrder) begin : g_in_order
    logic [MetaIdWidth-1:0]    head_q, head_d;
    logic [NumOutstanding-1:0] valid_q, valid_d;
    logic [DataWidth-1:0]      data_q [NumOutstanding];
    logic                      wr_ok;

    // A response may only fill a slot that is allocated and not yet filled.
    assign wr_ok     = in_resp_valid_i & alloc_q[in_resp_meta_id_i] & ~valid_q[in_resp_meta_id_i];
    assign proto_err = in_resp_valid_i & ~wr_ok;

    assign in_resp_ready_o = 1'b1;
    assign resp_valid_o    = valid_q[head_q];
    assign resp_data_o     = data_q[head_q];
    assign resp_meta_id_o  = head_q;

    assign rel_valid = resp_valid_o & resp_ready_i;
    assign rel_idx   = head_q;

    always_comb begin
      // NOTE: every combinational output gets a default first so no path holds
      // a stale value, which is what keeps this block from inferring latches.
      valid_d = valid_q;
      head_d  = head_q;
      if (rel_valid) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PtrOne;
      end
      // A write to head while it is valid is rejected by wr_ok, so the two never collide.
      if (wr_ok) begin
        valid_d[in_resp_meta_id_i] = 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        head_q  <= '0;
        valid_q <= '0;
      end else begin
        head_q  <= head_d;
        valid_q <= valid_d;
      end
    end

    // NOTE: slot payload storage has no reset; valid_q guards every read, so
    // clearing the data would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
      if (wr_ok) begin
        data_q[in_resp_meta_id_i] <= in_resp_data_i;
      end
    end
  end else begin : g_out_of_order
    logic resp_hs;

    assign in_resp_ready_o = resp_ready_i;
    assign resp_valid_o    = in_resp_valid_i;
    assign resp_data_o     = in_resp_data_i;
    assign resp_meta_id_o  = in_resp_meta_id_i;

    assign resp_hs = in_resp_valid_i & resp_ready_i;

    // Stray responses are still forwarded but must not corrupt the count.
    assign rel_valid = resp_hs & alloc_q[in_resp_meta_id_i];
    assign rel_idx   = in_resp_meta_id_i;
    assign proto_err = resp_hs & ~alloc_q[in_resp_meta_id_i];
  end

  // ---------------------------------------------------------------------------
  // Slot bookkeeping shared by both modes
  // ---------------------------------------------------------------------------
  always_comb begin
    alloc_d = alloc_q;
    tail_d  = tail_q;
    if (rel_valid) begin
      alloc_d[rel_idx] = 1'b0;
    end
    // push requires alloc_q[tail_q] clear, so it never targets the freed slot.
    if (push) begin
      alloc_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrOne;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, rel_valid})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  assign error_d = error_q | proto_err;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values; next-state logic above is
  // blocking inside always_comb because it is evaluated in order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      error_q <= 1'b0;
    end else begin
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      error_q <= error_d;
    end
  end

  assign outstanding_o = count_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_tcdm_resp_reorder_buffer.sv
// Self-checking bench: an in-order and a pass-through instance (depth 4) driven
// side by side, with a scoreboard queue of expected core responses.
module tb_tcdm_resp_reorder_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared request/response field inputs
  logic [31:0] req_addr, req_data, in_resp_data;
  logic        req_wen, out_req_ready;
  logic [3:0]  req_be, req_amo;
  logic [1:0]  in_resp_meta_id;

  // In-order instance (a_)
  logic        a_req_valid, a_req_ready, a_out_req_valid, a_out_req_wen;
  logic [31:0] a_out_req_addr, a_out_req_data, a_resp_data;
  logic [3:0]  a_out_req_be, a_out_req_amo;
  logic [1:0]  a_out_req_meta_id, a_resp_meta_id;
  logic        a_in_resp_valid, a_in_resp_ready, a_resp_valid, a_resp_ready, a_error;
  logic [2:0]  a_outstanding;

  // Pass-through instance (b_)
  logic        b_req_valid, b_req_ready, b_out_req_valid, b_out_req_wen;
  logic [31:0] b_out_req_addr, b_out_req_data, b_resp_data;
  logic [3:0]  b_out_req_be, b_out_req_amo;
  logic [1:0]  b_out_req_meta_id, b_resp_meta_id;
  logic        b_in_resp_valid, b_in_resp_ready, b_resp_valid, b_resp_ready, b_error;
  logic [2:0]  b_outstanding;

  tcdm_resp_reorder_buffer #(.NumOutstanding(4), .DataWidth(32), .AddrWidth(32), .InOrder(1'b1)) u_in_order (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(req_addr), .req_wen_i(req_wen),
    .req_be_i(req_be), .req_data_i(req_data), .req_amo_i(req_amo),
    .out_req_valid_o(a_out_req_valid), .out_req_ready_i(out_req_ready), .out_req_addr_o(a_out_req_addr),
    .out_req_wen_o(a_out_req_wen), .out_req_be_o(a_out_req_be), .out_req_data_o(a_out_req_data),
    .out_req_amo_o(a_out_req_amo), .out_req_meta_id_o(a_out_req_meta_id),
    .in_resp_valid_i(a_in_resp_valid), .in_resp_ready_o(a_in_resp_ready),
    .in_resp_meta_id_i(in_resp_meta_id), .in_resp_data_i(in_resp_data),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_data_o(a_resp_data),
    .resp_meta_id_o(a_resp_meta_id), .outstanding_o(a_outstanding), .error_o(a_error)
  );

  tcdm_resp_reorder_buffer #(.NumOutstanding(4), .DataWidth(32), .AddrWidth(32), .InOrder(1'b0)) u_out_of_order (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(req_addr), .req_wen_i(req_wen),
    .req_be_i(req_be), .req_data_i(req_data), .req_amo_i(req_amo),
    .out_req_valid_o(b_out_req_valid), .out_req_ready_i(out_req_ready), .out_req_addr_o(b_out_req_addr),
    .out_req_wen_o(b_out_req_wen), .out_req_be_o(b_out_req_be), .out_req_data_o(b_out_req_data),
    .out_req_amo_o(b_out_req_amo), .out_req_meta_id_o(b_out_req_meta_id),
    .in_resp_valid_i(b_in_resp_valid), .in_resp_ready_o(b_in_resp_ready),
    .in_resp_meta_id_i(in_resp_meta_id), .in_resp_data_i(in_resp_data),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_data_o(b_resp_data),
    .resp_meta_id_o(b_resp_meta_id), .outstanding_o(b_outstanding), .error_o(b_error)
  );

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic test_reset();
    rst_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_in_resp_valid = 0; b_in_resp_valid = 0;
    a_resp_ready = 0; b_resp_ready = 0; out_req_ready = 1;
    req_addr = '0; req_data = '0; req_wen = 0; req_be = 4'hF; req_amo = '0;
    in_resp_meta_id = '0; in_resp_data = '0;
    #12;
    checks++; if (a_outstanding !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", a_outstanding); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", a_error); end
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b want 0", a_resp_valid); end
    checks++; if (a_out_req_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", a_out_req_valid); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", a_req_ready); end
    checks++; if (b_outstanding !== 3'd0 || b_error !== 1'b0) begin errors++; $display("FAIL reset_b: cnt %0d err %0b want 0/0", b_outstanding, b_error); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Four reads fill the in-order instance; the fifth must be refused.
  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req_valid = 1; req_addr = 32'hA0 + 32'(i); req_wen = 0;
      #1;
      checks++; if (a_req_ready !== 1'b1 || a_out_req_valid !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: rdy %0b vld %0b want 1/1", i, a_req_ready, a_out_req_valid); end
      checks++; if (a_out_req_meta_id !== 2'(i)) begin errors++; $display("FAIL fill_tag[%0d]: got %0d want %0d", i, a_out_req_meta_id, i); end
      checks++; if (a_out_req_addr !== req_addr) begin errors++; $display("FAIL fill_addr[%0d]: got %h want %h", i, a_out_req_addr, req_addr); end
      sb.push_back('{tag: 2'(i), data: 32'hA + 32'(i)});
    end
    @(negedge clk);
    req_addr = 32'hA4;
    #1;
    checks++; if (a_req_ready !== 1'b0 || a_out_req_valid !== 1'b0) begin errors++; $display("FAIL full_stall: rdy %0b vld %0b want 0/0", a_req_ready, a_out_req_valid); end
    checks++; if (a_outstanding !== 3'd4) begin errors++; $display("FAIL full_cnt: got %0d want 4", a_outstanding); end
    a_req_valid = 0;
  endtask

  // Responses arrive as tags 2,0,3,1; the core must see A,B,C,D.
  task automatic test_reorder();
    logic [1:0] tags [4];
    logic [7:0] vis;
    tags = '{2'd2, 2'd0, 2'd3, 2'd1};
    vis  = 8'b0111_0100;  // cycles where the head slot is expected to be visible
    a_resp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        a_in_resp_valid = 1; in_resp_meta_id = tags[c]; in_resp_data = 32'hA + 32'(tags[c]);
      end else begin
        a_in_resp_valid = 0;
      end
      #1;
      checks++; if (a_resp_valid !== vis[c]) begin errors++; $display("FAIL reorder_vis[%0d]: got %0b want %0b", c, a_resp_valid, vis[c]); end
      if (a_resp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL reorder_extra[%0d]: got data %h want none", c, a_resp_data); end
        else begin
          e = sb.pop_front();
          if (a_resp_data !== e.data || a_resp_meta_id !== e.tag) begin errors++; $display("FAIL reorder_data[%0d]: got %h/%0d want %h/%0d", c, a_resp_data, a_resp_meta_id, e.data, e.tag); end
        end
      end
    end
    checks++; if (sb.size() != 0 || a_outstanding !== 3'd0) begin errors++; $display("FAIL reorder_drain: left %0d cnt %0d want 0/0", sb.size(), a_outstanding); end
  endtask

  // Head held under backpressure, then popped while a new request reuses tag 0.
  task automatic test_hold_and_wrap();
    a_resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req_valid = 1; req_addr = 32'hB0 + 32'(i);
      #1;
      checks++; if (a_out_req_meta_id !== 2'(i)) begin errors++; $display("FAIL wrap_tag[%0d]: got %0d want %0d", i, a_out_req_meta_id, i); end
      sb.push_back('{tag: 2'(i), data: 32'h10 + 32'(i)});
    end
    @(negedge clk);
    a_req_valid = 0; a_in_resp_valid = 1; in_resp_meta_id = 2'd0; in_resp_data = 32'h10;
    @(negedge clk);
    in_resp_meta_id = 2'd1; in_resp_data = 32'h11; a_resp_ready = 1;
    #1;
    e = sb.pop_front();
    checks++; if (a_resp_valid !== 1'b1 || a_resp_data !== e.data) begin errors++; $display("FAIL hold_first: vld %0b data %h want 1/%h", a_resp_valid, a_resp_data, e.data); end
    @(negedge clk);
    a_in_resp_valid = 0; a_resp_ready = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h11) begin errors++; $display("FAIL hold_stable[%0d]: vld %0b data %h want 1/11", c, a_resp_valid, a_resp_data); end
    end
    @(negedge clk);
    a_resp_ready = 1; a_req_valid = 1; req_addr = 32'hC0;
    #1;
    e = sb.pop_front();
    checks++; if (a_resp_valid !== 1'b1 || a_resp_data !== e.data || a_resp_meta_id !== e.tag) begin errors++; $display("FAIL hold_pop: got %0b/%h/%0d want 1/%h/%0d", a_resp_valid, a_resp_data, a_resp_meta_id, e.data, e.tag); end
    checks++; if (a_req_ready !== 1'b1 || a_out_req_meta_id !== 2'd0) begin errors++; $display("FAIL wrap_reissue: rdy %0b tag %0d want 1/0", a_req_ready, a_out_req_meta_id); end
    sb.push_back('{tag: 2'd0, data: 32'h20});
    @(negedge clk);
    a_req_valid = 0; a_resp_ready = 0;
    #1;
    checks++; if (a_outstanding !== 3'd3) begin errors++; $display("FAIL wrap_cnt: got %0d want 3", a_outstanding); end
    // Drain remaining slots 2,3,0 in order with a bounded loop.
    a_resp_ready = 1;
    for (int k = 0; k < 12 && sb.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      case (k)
        0: begin a_in_resp_valid = 1; in_resp_meta_id = 2'd2; in_resp_data = 32'h12; end
        1: begin a_in_resp_valid = 1; in_resp_meta_id = 2'd3; in_resp_data = 32'h13; end
        2: begin a_in_resp_valid = 1; in_resp_meta_id = 2'd0; in_resp_data = 32'h20; end
        default: a_in_resp_valid = 0;
      endcase
      #1;
      if (a_resp_valid === 1'b1) begin
        e = sb.pop_front();
        checks++; if (a_resp_data !== e.data || a_resp_meta_id !== e.tag) begin errors++; $display("FAIL drain_data[%0d]: got %h/%0d want %h/%0d", k, a_resp_data, a_resp_meta_id, e.data, e.tag); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d responses missing, want 0", sb.size()); end
    @(negedge clk);
    a_in_resp_valid = 0; a_resp_ready = 0;
    #1;
    checks++; if (a_outstanding !== 3'd0) begin errors++; $display("FAIL drain_cnt: got %0d want 0", a_outstanding); end
  endtask

  // A response to an unallocated slot is dropped and flags a sticky error.
  task automatic test_error();
    @(negedge clk);
    a_in_resp_valid = 1; in_resp_meta_id = 2'd3; in_resp_data = 32'hDEAD;
    #1;
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL err_early: got %0b want 0", a_error); end
    @(negedge clk);
    a_in_resp_valid = 0;
    #1;
    checks++; if (a_error !== 1'b1) begin errors++; $display("FAIL err_set: got %0b want 1", a_error); end
    checks++; if (a_resp_valid !== 1'b0 || a_outstanding !== 3'd0) begin errors++; $display("FAIL err_dropped: vld %0b cnt %0d want 0/0", a_resp_valid, a_outstanding); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", a_error); end
  endtask

  // Pass-through mode: arrival-order forwarding, backpressure, busy-tail stall.
  task automatic test_out_of_order();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_req_valid = 1; req_addr = 32'hD0 + 32'(i);
      #1;
      checks++; if (b_out_req_meta_id !== 2'(i) || b_req_ready !== 1'b1) begin errors++; $display("FAIL ooo_tag[%0d]: tag %0d rdy %0b want %0d/1", i, b_out_req_meta_id, b_req_ready, i); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_req_valid = 0; b_resp_ready = 1; b_in_resp_valid = 1;
      in_resp_meta_id = 2'(1 - i); in_resp_data = 32'h21 - 32'(i);
      sb.push_back('{tag: 2'(1 - i), data: 32'h21 - 32'(i)});
      #1;
      e = sb.pop_front();
      checks++; if (b_resp_valid !== 1'b1 || b_in_resp_ready !== 1'b1) begin errors++; $display("FAIL ooo_fwd_vld[%0d]: vld %0b rdy %0b want 1/1", i, b_resp_valid, b_in_resp_ready); end
      checks++; if (b_resp_meta_id !== e.tag || b_resp_data !== e.data) begin errors++; $display("FAIL ooo_fwd_data[%0d]: got %0d/%h want %0d/%h", i, b_resp_meta_id, b_resp_data, e.tag, e.data); end
    end
    @(negedge clk);
    b_resp_ready = 0;
    #1;
    checks++; if (b_in_resp_ready !== 1'b0) begin errors++; $display("FAIL ooo_backpressure: got %0b want 0", b_in_resp_ready); end
    b_in_resp_valid = 0;
    #1;
    checks++; if (b_outstanding !== 3'd0 || b_error !== 1'b0) begin errors++; $display("FAIL ooo_clean: cnt %0d err %0b want 0/0", b_outstanding, b_error); end
    // Fill with tags 2,3,0,1, free tag 0 only: tail slot 2 is still busy.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_req_valid = 1;
    end
    @(negedge clk);
    b_req_valid = 0; b_resp_ready = 1; b_in_resp_valid = 1; in_resp_meta_id = 2'd0;
    @(negedge clk);
    b_req_valid = 1; in_resp_meta_id = 2'd2;
    #1;
    checks++; if (b_req_ready !== 1'b0 || b_out_req_valid !== 1'b0) begin errors++; $display("FAIL ooo_busy_tail: rdy %0b vld %0b want 0/0", b_req_ready, b_out_req_valid); end
    checks++; if (b_outstanding !== 3'd3) begin errors++; $display("FAIL ooo_cnt: got %0d want 3", b_outstanding); end
    @(negedge clk);
    b_in_resp_valid = 0;
    #1;
    checks++; if (b_req_ready !== 1'b1 || b_out_req_meta_id !== 2'd2) begin errors++; $display("FAIL ooo_reuse: rdy %0b tag %0d want 1/2", b_req_ready, b_out_req_meta_id); end
    @(negedge clk);
    b_req_valid = 0; b_resp_ready = 0;
  endtask

  // Asynchronous reset with requests in flight, then a stale response.
  task automatic test_reset_mid();
    logic [1:0] first_tag;
    out_req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_req_valid = 1;
      #1;
      if (i == 0) first_tag = a_out_req_meta_id;
    end
    @(negedge clk);
    a_req_valid = 0; a_in_resp_valid = 1; in_resp_meta_id = first_tag; in_resp_data = 32'h55;
    @(negedge clk);
    a_in_resp_valid = 0;
    #1;
    checks++; if (a_resp_valid !== 1'b1 || a_outstanding !== 3'd3) begin errors++; $display("FAIL mid_pre: vld %0b cnt %0d want 1/3", a_resp_valid, a_outstanding); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (a_resp_valid !== 1'b0 || a_outstanding !== 3'd0 || a_error !== 1'b0) begin errors++; $display("FAIL mid_async: vld %0b cnt %0d err %0b want 0/0/0", a_resp_valid, a_outstanding, a_error); end
    checks++; if (b_outstanding !== 3'd0) begin errors++; $display("FAIL mid_async_b: cnt %0d want 0", b_outstanding); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    a_in_resp_valid = 1; in_resp_meta_id = 2'd1; in_resp_data = 32'h66;
    @(negedge clk);
    a_in_resp_valid = 0;
    #1;
    checks++; if (a_error !== 1'b1 || a_outstanding !== 3'd0) begin errors++; $display("FAIL mid_stale: err %0b cnt %0d want 1/0", a_error, a_outstanding); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reorder();
    test_hold_and_wrap();
    test_error();
    test_out_of_order();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
